// File: rtl/muldiv_seq.sv
// muldiv_seq: radix-2 iterative MULT/MULTU/DIV/DIVU owning HI/LO; MULDIV_EARLY_OUT_EN skips CALC on zero src_b.
// Latency: done in the cycle after edge E(WIDTH+1) (after E1 on the early-out path); busy covers the whole run.
// No backpressure: start is ignored while busy, flush aborts without touching HI/LO.
module muldiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             flush,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t               state, state_nxt;
  logic [CW-1:0]        cnt;
  logic                 is_div, negq, negr, dz;
  logic [WIDTH-1:0]     opa, opb;
  logic [2*WIDTH-1:0]   acc;
  logic [WIDTH:0]       rem;

  logic                 sa, sb;
  logic [WIDTH-1:0]     amag, bmag;
  logic [WIDTH-1:0]     mul_add;
  logic [WIDTH:0]       mul_sum;
  logic [WIDTH:0]       div_sh, div_diff;
  logic                 div_ok;
  logic [2*WIDTH-1:0]   prod_fix;
  logic [WIDTH-1:0]     q_fix, r_fix, a_orig;

  // op[0]=0 selects the signed variants
  assign sa   = ~op[0] & src_a[WIDTH-1];
  assign sb   = ~op[0] & src_b[WIDTH-1];
  assign amag = sa ? -src_a : src_a;
  assign bmag = sb ? -src_b : src_b;

  // Multiply: acc = {partial product, remaining multiplier bits}
  assign mul_add = acc[0] ? opa : '0;
  assign mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, mul_add};

  // Restoring divide: quotient bits shift into acc[WIDTH-1:0] as dividend bits leave
  assign div_sh   = {rem[WIDTH-1:0], acc[WIDTH-1]};
  assign div_diff = div_sh - {1'b0, opb};
  assign div_ok   = ~div_diff[WIDTH];

  assign prod_fix = negq ? -acc : acc;
  assign q_fix    = negq ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  assign r_fix    = negr ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
  assign a_orig   = negr ? -opa : opa;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: if (start) begin
`ifdef MULDIV_EARLY_OUT_EN
          state_nxt = (bmag == '0) ? FIX : CALC;
`else
          state_nxt = CALC;
`endif
        end
        CALC:    if (cnt == CW'(1)) state_nxt = FIX;
        FIX:     state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy   <= 1'b0;
      done   <= 1'b0;
      hi     <= '0;
      lo     <= '0;
      cnt    <= '0;
      is_div <= 1'b0;
      negq   <= 1'b0;
      negr   <= 1'b0;
      dz     <= 1'b0;
      opa    <= '0;
      opb    <= '0;
      acc    <= '0;
      rem    <= '0;
    end else begin
      done <= 1'b0;
      if (flush) begin
        busy <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (hi_we) hi <= wdata;
            if (lo_we) lo <= wdata;
            if (start) begin
              busy   <= 1'b1;
              cnt    <= CW'(WIDTH);
              is_div <= op[1];
              negq   <= sa ^ sb;
              negr   <= sa;
              dz     <= (bmag == '0);
              opa    <= amag;
              opb    <= bmag;
              acc    <= {{WIDTH{1'b0}}, (op[1] ? amag : bmag)};
              rem    <= '0;
            end
          end
          CALC: begin
            cnt <= cnt - 1'b1;
            if (is_div) begin
              acc[WIDTH-1:0] <= {acc[WIDTH-2:0], div_ok};
              rem            <= div_ok ? div_diff : div_sh;
            end else begin
              acc <= {mul_sum, acc[WIDTH-1:1]};
            end
          end
          FIX: begin
            busy <= 1'b0;
            done <= 1'b1;
            if (!is_div) begin
              hi <= prod_fix[2*WIDTH-1:WIDTH];
              lo <= prod_fix[WIDTH-1:0];
            end else if (dz) begin
              // Divide by zero bypasses the sign fix-up: HI returns the dividend as issued
              hi <= a_orig;
              lo <= '1;
            end else begin
              hi <= r_fix;
              lo <= q_fix;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
- Multi-cycle sequencer for the integer multiply/divide resource behind the ALU.
- Executes MULT, MULTU, DIV and DIVU iteratively: one partial product or quotient bit per clock, radix-2.
- Owns the architectural HI/LO registers, serves MFHI/MFLO reads, and accepts MTHI/MTLO writes.
- Drives busy to the hazard unit so the pipeline stalls any HI/LO consumer until the result lands.

Parameters:
- WIDTH, 32, operand width; HI/LO are WIDTH bits each; iteration count = WIDTH.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  launch request; sampled only in IDLE.
- op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- src_a  in  WIDTH  multiplicand / dividend.
- src_b  in  WIDTH  multiplier / divisor.
- flush  in  1  abort the in-flight operation (exception or branch squash).
- hi_we  in  1  MTHI write enable.
- lo_we  in  1  MTLO write enable.
- wdata  in  WIDTH  MTHI/MTLO data.
- busy  out  1  high while an operation is in flight.
- done  out  1  one-cycle pulse when HI/LO are updated by an operation.
- hi  out  WIDTH  HI register (product[2W-1:W] or remainder).
- lo  out  WIDTH  LO register (product[W-1:0] or quotient).

Behaviour:
- Reset values (async on rst_n=0):
  - State = IDLE.
  - busy=0, done=0, hi=0, lo=0.
  - Iteration counter = 0, internal accumulators = 0.
- FSM states: IDLE -> CALC -> FIX -> IDLE.
- IDLE: on a clock edge with start=1, latch op and the operand magnitudes.
  - Signed ops (MULT, DIV) take the absolute value of each operand and record the result sign.
  - Record negq = sign_a XOR sign_b and negr = sign_a.
  - Counter loads WIDTH; move to CALC; busy=1 from the next cycle.
- CALC, one iteration per edge, counter decrements:
  - Multiply: shift-add on a 2W accumulator.
  - Divide: restoring shift-subtract, where the remainder is W+1 bits wide.
  - Move to FIX when the counter reaches 1 at the edge.
- FIX (one edge):
  - Apply the sign fix-up: two's-complement negate of the 2W product if negq; for division, negate the quotient if negq and the remainder if negr (remainder takes the sign of the dividend).
  - Write hi/lo, pulse done=1 for exactly the next cycle, busy=0, return to IDLE.
- Latency: start edge E0; hi/lo valid and done=1 in the cycle after edge E(WIDTH+1); busy high for WIDTH+1 cycles.
- Divide by zero (src_b=0):
  - No trap is raised.
  - Result is lo = all ones and hi = src_a, unmodified by the sign fix-up.
  - Normal latency unless the optional feature below is compiled in.
- Signed overflow (DIV of most-negative by -1): lo = most-negative value, hi = 0; this falls out of the sign fix-up naturally.
- start while busy=1: ignored; no queuing.
- flush:
  - Takes priority over every other input.
  - In CALC or FIX: return to IDLE next edge, busy=0, done stays 0, hi/lo unchanged.
  - In IDLE: suppresses a same-cycle start.
- hi_we/lo_we:
  - Honoured only when busy=0, and they write on the edge.
  - In the same IDLE edge as a start, both take effect; the write happens now and the operation result overwrites it later.
  - While busy=1 they are ignored; the stall logic guarantees they are not issued.
- Operands are captured at start; later changes on src_a/src_b have no effect.
- All outputs are registered; there is no combinational path from the inputs to busy, done, hi or lo.

Optional Feature:
- Macro: MULDIV_EARLY_OUT_EN.
- Defined: at start, if the magnitude of src_b is 0, skip CALC and go straight to FIX.
  - Multiply: hi=lo=0.
  - Divide: hi=src_a, lo=all ones.
  - done appears in the cycle after edge E1; busy is high for 1 cycle.
- Undefined: every operation takes the full WIDTH+1 cycles, including zero operands.
- Result values are identical in both builds.

Test Plan:
- MULT src_a=-3 (0xFFFFFFFD), src_b=7 -> after 33 busy cycles: done pulse, hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001, done high exactly 1 cycle.
- DIV -7 / 2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). DIVU 100 / 7 -> lo=14, hi=2.
- DIVU 5 / 0 -> lo=0xFFFFFFFF, hi=5. Latency is 33 cycles without the macro and 1 busy cycle with MULDIV_EARLY_OUT_EN.
- Pre-load hi=0x1234 via MTHI; start MULT; assert flush at busy cycle 10 -> busy=0 next cycle, done never pulses, hi=0x1234. A second start during busy is ignored.
- Assert rst_n=0 mid-CALC -> busy, done, hi and lo are all 0 immediately (asynchronously); after release, a fresh MULTU 6 x 7 gives lo=42.
